// File: rtl/cache_refill_writer.sv
// Collects four memory beats in critical-word-first wrap order into one cache line and writes it to a way.
// Latency: critical word visible one cycle after its beat; line write one cycle after the fourth beat.
// Backpressure: req_ready only in IDLE, mem_ready only in FILL; memory stalls hold all state.
module cache_refill_writer #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_way,
  input  logic [1:0]          req_word,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic                crit_valid,
  output logic [DATA_W-1:0]   crit_data,
  output logic [3:0]          line_we,
  output logic [4*DATA_W-1:0] line_data,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_way;
  logic [1:0]          r_ptr;
  logic [1:0]          r_beat_cnt;
  logic                r_req_ready;
  logic                r_mem_ready;
  logic                r_crit_valid;
  logic [DATA_W-1:0]   r_crit_data;
  logic [3:0]          r_line_we;
  logic                r_done;
  logic [4*DATA_W-1:0] r_line_data;

  // Handshakes qualify only on registered readies, which are themselves tied to the state,
  // so no request or memory input reaches an output combinationally.
  logic w_req_acc;
  logic w_beat_acc;
  logic w_last_beat;

  assign w_req_acc   = req_valid && r_req_ready;
  assign w_beat_acc  = mem_valid && r_mem_ready;
  assign w_last_beat = (r_beat_cnt == 2'd3);

  // Refill FSM: request latch, beat collection into the line buffer, and the one-cycle way write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_way        <= 2'd0;
      r_ptr        <= 2'd0;
      r_beat_cnt   <= 2'd0;
      r_req_ready  <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
      r_line_we    <= 4'b0000;
      r_done       <= 1'b0;
      r_line_data  <= '0;
    end else begin
      // Pulse outputs default low; they are raised for exactly one cycle below.
      r_crit_valid <= 1'b0;
      r_line_we    <= 4'b0000;
      r_done       <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // req_ready rises on the first edge after reset release and stays high while idle.
          r_req_ready <= 1'b1;
          if (w_req_acc) begin
            r_way       <= req_way;
            r_ptr       <= req_word;
            r_beat_cnt  <= 2'd0;
            r_req_ready <= 1'b0;
            r_mem_ready <= 1'b1;
            r_state     <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (w_beat_acc) begin
            // Only the word under the wrap pointer changes; untouched words keep old contents.
            for (int i = 0; i < 4; i++) begin
              if (r_ptr == 2'(i)) begin
                r_line_data[DATA_W*i +: DATA_W] <= mem_data;
              end
            end
            r_ptr      <= r_ptr + 2'd1;
            r_beat_cnt <= r_beat_cnt + 2'd1;

            // The first beat of a refill is the word the CPU is waiting on.
            if (r_beat_cnt == 2'd0) begin
              r_crit_data  <= mem_data;
              r_crit_valid <= 1'b1;
            end

            // Fourth beat completes the line; the write pulse lines up with the WRITE state.
            if (w_last_beat) begin
              r_mem_ready <= 1'b0;
              r_line_we   <= 4'b0001 << r_way;
              r_done      <= 1'b1;
              r_state     <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_req_ready <= 1'b0;
          r_mem_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign mem_ready  = r_mem_ready;
  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;
  assign line_we    = r_line_we;
  assign line_data  = r_line_data;
  assign done       = r_done;

endmodule

// File: doc/cache_refill_writer.md
# cache_refill_writer

Write-side counterpart of the cache read path. It accepts a refill request for one cache way and collects four 32-bit words from memory in critical-word-first, wrap-around order. It assembles them into a 128-bit line and writes that line into the selected way with a one-hot write enable. The first (critical) word is also forwarded to the CPU as soon as it arrives. The block sits between the memory response port and the four data-way arrays of the 4-way set-associative cache.

## Interface
- DATA_W, 32, width of one word; line is 4*DATA_W.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  refill request strobe.
- req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_way  input  2  destination way (0..3).
- req_word  input  2  critical word offset; first memory beat lands here.
- mem_valid  input  1  memory beat valid.
- mem_data  input  DATA_W  memory beat data.
- mem_ready  output  1  high only in FILL; beat accepted when mem_valid && mem_ready.
- crit_valid  output  1  one-cycle pulse carrying the critical word.
- crit_data  output  DATA_W  critical word, held until the next critical word.
- line_we  output  4  one-hot way write enable, asserted for one cycle.
- line_data  output  4*DATA_W  assembled line; word i at bits [DATA_W*i +: DATA_W].
- done  output  1  one-cycle pulse, coincident with line_we.

## Operation
- FSM states are IDLE, FILL and WRITE. Reset state is IDLE.
- IDLE: req_ready=1 and mem_ready=0. On accept, latch way and ptr=req_word, clear beat_cnt to 0, and go to FILL.
- FILL: req_ready=0 and mem_ready=1. On each accepted beat:
  - store mem_data into line word [ptr];
  - ptr <= ptr+1 mod 4 (wraps 3 -> 0);
  - beat_cnt <= beat_cnt+1.
- FILL, first accepted beat (beat_cnt==0): also register crit_data <= mem_data and pulse crit_valid the next cycle.
- FILL, beat with beat_cnt==3: go to WRITE. Exactly 4 beats are accepted per request. Stalls (mem_valid=0) of any length keep FILL and all state unchanged.
- WRITE: line_we = 4'b0001 << way and done=1 for this single cycle; line_data is complete and stable. Go to IDLE.
- req_valid outside IDLE is ignored and not queued. mem_valid outside FILL is ignored.
- line_data holds its value after WRITE until overwritten by the next refill's beats. Words not yet written in a new refill keep their old values.
- Reset values: req_ready=0 while rst_n low, and 1 in IDLE after release. mem_ready=0, crit_valid=0, crit_data=0, line_we=0, line_data=0, done=0; internal ptr, way and beat_cnt are 0.
- Reset asserted mid-FILL or in WRITE: return to IDLE immediately and clear all registers. No line_we or done is produced for the aborted refill.

## Timing
- Request accepted at edge 0. FILL occupies cycle 1 onward.
- With mem_valid held high, beats are accepted at edges 1–4, crit_valid is high in cycle 2, and WRITE (line_we, done) is cycle 5. IDLE and req_ready=1 return in cycle 6.
- Minimum request-to-request spacing is 6 cycles. Each stall cycle adds one cycle.
- crit_valid always precedes line_we by at least 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from mem_* or req_* to any output.

## Test plan
- Aligned refill: req_way=2, req_word=0, beats A0,A1,A2,A3 back-to-back. Expect:
  - crit_data=A0 with crit_valid in cycle 2;
  - line_we=4'b0100 in cycle 5;
  - line_data={A3,A2,A1,A0};
  - done=1 in cycle 5.
- Wrap-around: req_way=1, req_word=3, beats B0..B3. Expect:
  - word3=B0, word0=B1, word1=B2, word2=B3;
  - line_we=4'b0010;
  - crit_data=B0.
- Stalls: req_word=1, mem_valid toggling 1,0,0,1,1,0,1. Expect mem_ready high throughout FILL, exactly 4 beats stored in order, line_we one cycle after the 4th beat, and no extra writes.
- Ignored inputs: mem_valid=1 in IDLE with data C9 leaves line_data unchanged. A req_valid pulse during FILL with req_way=3 does not change the latched way, and line_we matches the original way.
- Reset mid-FILL: drop rst_n after 2 beats. Expect all outputs 0 and no line_we/done. After release, req_ready=1 and a fresh refill with req_word=2 completes correctly from beat 0.
- Back-to-back: second req_valid held high from cycle 5. Expect it accepted in cycle 6 (not 5), with both lines written to their own ways.
